// File: rtl/lcd_timing_pkg.sv
// Panel timing constants shared by the horizontal and vertical timing stages.
package lcd_timing_pkg;

  // Horizontal timing (pixels)
  localparam int unsigned LCD_HACTIVE = 800;
  localparam int unsigned LCD_HFRONT  = 16;
  localparam int unsigned LCD_HSYNC   = 30;
  localparam int unsigned LCD_HBACK   = 44;
  localparam int unsigned LCD_HTOTAL  = LCD_HACTIVE + LCD_HFRONT + LCD_HSYNC + LCD_HBACK;

  // Vertical timing (lines)
  localparam int unsigned LCD_VACTIVE = 480;
  localparam int unsigned LCD_VFRONT  = 13;
  localparam int unsigned LCD_VSYNC   = 3;
  localparam int unsigned LCD_VBACK   = 29;
  localparam int unsigned LCD_VTOTAL  = LCD_VACTIVE + LCD_VFRONT + LCD_VSYNC + LCD_VBACK;

  // Width of pixel/line counters
  localparam int unsigned LCD_CNT_W   = 10;

  // Vertical stage lock state
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vstate_t;

endpackage

// File: rtl/vsync_gen.sv
// Vertical timing stage: counts lines from the horizontal stage's column
// index and produces registered vsync, data-enables, line index and a
// frame-start pulse, all one clock behind their inputs.
module vsync_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned HTOTAL  = LCD_HTOTAL,
  parameter int unsigned VACTIVE = LCD_VACTIVE,
  parameter int unsigned VFRONT  = LCD_VFRONT,
  parameter int unsigned VSYNC   = LCD_VSYNC,
  parameter int unsigned VBACK   = LCD_VBACK
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_x,
  input  logic       i_hsync,
  input  logic       i_hde,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_vde,
  output logic       o_de,
  output logic [9:0] o_y,
  output logic       o_frame_start,
  output logic       o_locked
);

  localparam int unsigned VTOTAL      = VACTIVE + VFRONT + VSYNC + VBACK;
  localparam int unsigned VSYNC_START = VACTIVE + VFRONT;
  localparam int unsigned VSYNC_END   = VSYNC_START + VSYNC;

  // Line compares are done at 11 bits so a window ending at 1024 still works.
  localparam logic [9:0]  X_LAST = 10'(HTOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(VTOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(VACTIVE);
  localparam logic [10:0] V_SS   = 11'(VSYNC_START);
  localparam logic [10:0] V_SE   = 11'(VSYNC_END);

  vstate_t     r_state;
  logic [9:0]  r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_vde;
  logic        r_de;
  logic [9:0]  r_y;
  logic        r_frame_start;
  logic        r_locked;

  vstate_t     w_state_nxt;
  logic [9:0]  w_vcount_nxt;
  logic [10:0] w_vc;
  logic        w_line_end;
  logic        w_run;
  logic        w_wrap;
  logic        w_vact;
  logic        w_vsync_win;

  // Lock state and line counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_vcount <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_vcount <= w_vcount_nxt;
    end
  end

  // Next-state, next line count and vertical window decode
  always_comb begin
    w_line_end   = (i_x == X_LAST);
    w_run        = (r_state == RUN);
    w_wrap       = (r_vcount == V_LAST);
    w_vc         = {1'b0, r_vcount};
    w_vact       = w_run && (w_vc < V_ACT);
    w_vsync_win  = w_run && (w_vc >= V_SS) && (w_vc < V_SE);
    w_state_nxt  = r_state;
    w_vcount_nxt = r_vcount;
    case (r_state)
      IDLE: begin
        w_vcount_nxt = '0;
        if (w_line_end) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_line_end) w_vcount_nxt = w_wrap ? '0 : r_vcount + 10'd1;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_vcount_nxt = '0;
      end
    endcase
  end

  // Output registers, all sampled from pre-update count and current inputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_vde         <= 1'b0;
      r_de          <= 1'b0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_hsync       <= i_hsync;
      r_vsync       <= ~w_vsync_win;
      r_vde         <= w_vact;
      r_de          <= i_hde & w_vact;
      r_y           <= r_vcount;
      r_frame_start <= w_line_end & (~w_run | w_wrap);
      r_locked      <= w_run;
    end
  end

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_vde         = r_vde;
  assign o_de          = r_de;
  assign o_y           = r_y;
  assign o_frame_start = r_frame_start;
  assign o_locked      = r_locked;

endmodule

// File: tb/tb_vsync_gen.sv
// Directed bench for vsync_gen: a small-parameter instance for line/frame
// behaviour and a default-parameter instance for panel timing.
module tb_vsync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: HTOTAL 8, VTOTAL 8 (active 0..3, sync 5..6)
  logic       s_rst = 1'b1;
  logic [9:0] s_x   = '0;
  logic       s_hs  = 1'b1;
  logic       s_hde = 1'b0;
  logic       s_ohs, s_ovs, s_vde, s_de, s_fs, s_lk;
  logic [9:0] s_y;

  // Default instance: HTOTAL 890, VTOTAL 525
  logic       d_rst = 1'b1;
  logic [9:0] d_x   = '0;
  logic       d_hs  = 1'b1;
  logic       d_hde = 1'b0;
  logic       d_ohs, d_ovs, d_vde, d_de, d_fs, d_lk;
  logic [9:0] d_y;

  vsync_gen #(
    .HTOTAL (8),
    .VACTIVE(4),
    .VFRONT (1),
    .VSYNC  (2),
    .VBACK  (1)
  ) u_small (
    .i_clk        (clk),
    .i_rst        (s_rst),
    .i_x          (s_x),
    .i_hsync      (s_hs),
    .i_hde        (s_hde),
    .o_hsync      (s_ohs),
    .o_vsync      (s_ovs),
    .o_vde        (s_vde),
    .o_de         (s_de),
    .o_y          (s_y),
    .o_frame_start(s_fs),
    .o_locked     (s_lk)
  );

  vsync_gen u_dflt (
    .i_clk        (clk),
    .i_rst        (d_rst),
    .i_x          (d_x),
    .i_hsync      (d_hs),
    .i_hde        (d_hde),
    .o_hsync      (d_ohs),
    .o_vsync      (d_ovs),
    .o_vde        (d_vde),
    .o_de         (d_de),
    .o_y          (d_y),
    .o_frame_start(d_fs),
    .o_locked     (d_lk)
  );

  // Observed vectors: {hsync, vsync, vde, de, y[9:0], frame_start, locked}
  logic [15:0] s_obs, d_obs;
  assign s_obs = {s_ohs, s_ovs, s_vde, s_de, s_y, s_fs, s_lk};
  assign d_obs = {d_ohs, d_ovs, d_vde, d_de, d_y, d_fs, d_lk};

  localparam logic [15:0] RST_VEC = 16'hC000;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both instances held in reset with live inputs: outputs pinned at reset values
  task automatic test_reset();
    s_rst = 1'b1; d_rst = 1'b1;
    s_hs  = 1'b0; d_hs  = 1'b0;
    s_hde = 1'b1; d_hde = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d_x = 10'(395 + k);
      s_x = 10'(k);
      tick();
      n_cmp++;
      if (d_obs !== RST_VEC) begin
        n_bad++;
        $display("FAIL reset_dflt k=%0d: got %h expected %h", k, d_obs, RST_VEC);
      end
      n_cmp++;
      if (s_obs !== RST_VEC) begin
        n_bad++;
        $display("FAIL reset_small k=%0d: got %h expected %h", k, s_obs, RST_VEC);
      end
    end
  endtask

  // Release mid-line at x=400; lock at x=889; then two locked lines
  task automatic test_lock_default();
    logic [15:0] exp;
    d_rst = 1'b0;
    for (int x = 400; x < 890; x++) begin
      d_x   = 10'(x);
      d_hs  = (x % 3) != 0;
      d_hde = 1'b1;
      tick();
      exp = {d_hs, 1'b1, 1'b0, 1'b0, 10'd0, (x == 889), 1'b0};
      n_cmp++;
      if (d_obs !== exp) begin
        n_bad++;
        $display("FAIL lock_dflt x=%0d: got %h expected %h", x, d_obs, exp);
      end
    end
    for (int n = 0; n < 2; n++) begin
      for (int x = 0; x < 890; x++) begin
        d_x   = 10'(x);
        d_hde = (x < 800);
        d_hs  = !(x >= 816 && x < 846);
        tick();
        exp = {d_hs, 1'b1, 1'b1, d_hde, 10'(n), 1'b0, 1'b1};
        n_cmp++;
        if (d_obs !== exp) begin
          n_bad++;
          $display("FAIL run_dflt n=%0d x=%0d: got %h expected %h", n, x, d_obs, exp);
        end
      end
    end
  endtask

  // x held at 889 makes every clock a line end: two full 525-line frames
  task automatic test_default_frame();
    logic [15:0] exp;
    logic        vact;
    int          n;
    int          vde_cnt;
    int          fs_cnt;
    d_rst = 1'b1;
    tick();
    d_x   = 10'd889;
    d_hs  = 1'b1;
    d_hde = 1'b1;
    d_rst = 1'b0;
    tick();
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0};
    n_cmp++;
    if (d_obs !== exp) begin
      n_bad++;
      $display("FAIL frame_dflt_lock: got %h expected %h", d_obs, exp);
    end
    vde_cnt = 0;
    fs_cnt  = 0;
    for (int c = 0; c < 1050; c++) begin
      n = c % 525;
      d_hs = (c % 2) == 0;
      tick();
      vact = (n < 480);
      exp = {d_hs, !(n >= 493 && n < 496), vact, vact, 10'(n), (n == 524), 1'b1};
      n_cmp++;
      if (d_obs !== exp) begin
        n_bad++;
        $display("FAIL frame_dflt n=%0d: got %h expected %h", n, d_obs, exp);
      end
      if (c < 525) begin
        if (d_vde === 1'b1) vde_cnt++;
        if (d_fs === 1'b1) fs_cnt++;
      end
    end
    n_cmp++;
    if (vde_cnt !== 480) begin
      n_bad++;
      $display("FAIL frame_dflt_vde_lines: got %0d expected 480", vde_cnt);
    end
    n_cmp++;
    if (fs_cnt !== 1) begin
      n_bad++;
      $display("FAIL frame_dflt_fs_count: got %0d expected 1", fs_cnt);
    end
  endtask

  // Lock, then one full frame of line counting with hde/hsync alignment
  task automatic test_line_count();
    logic [15:0] exp;
    s_rst = 1'b0;
    s_hde = 1'b1;
    for (int x = 3; x < 8; x++) begin
      s_x  = 10'(x);
      s_hs = (x != 4);
      tick();
      exp = {s_hs, 1'b1, 1'b0, 1'b0, 10'd0, (x == 7), 1'b0};
      n_cmp++;
      if (s_obs !== exp) begin
        n_bad++;
        $display("FAIL lock_small x=%0d: got %h expected %h", x, s_obs, exp);
      end
    end
    for (int n = 0; n < 8; n++) begin
      for (int x = 0; x < 8; x++) begin
        s_x   = 10'(x);
        s_hde = (x < 5);
        s_hs  = !(x == 5 || x == 6);
        tick();
        exp = {s_hs, !(n == 5 || n == 6), (n < 4), s_hde && (n < 4), 10'(n),
               (n == 7 && x == 7), 1'b1};
        n_cmp++;
        if (s_obs !== exp) begin
          n_bad++;
          $display("FAIL line_count n=%0d x=%0d: got %h expected %h", n, x, s_obs, exp);
        end
      end
    end
  endtask

  // Three more frames: one pulse per 64 clocks, on the last pixel of line 7
  task automatic test_wrap();
    int fs_cnt;
    int last_c;
    int c;
    fs_cnt = 0;
    last_c = -1;
    c = 0;
    s_hde = 1'b0;
    s_hs  = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 8; n++) begin
        for (int x = 0; x < 8; x++) begin
          s_x = 10'(x);
          tick();
          n_cmp++;
          if (s_y !== 10'(n)) begin
            n_bad++;
            $display("FAIL wrap_y f=%0d n=%0d x=%0d: got %0d expected %0d", f, n, x, s_y, n);
          end
          if (s_fs === 1'b1) begin
            fs_cnt++;
            n_cmp++;
            if (!(n == 7 && x == 7)) begin
              n_bad++;
              $display("FAIL wrap_fs_pos: got n=%0d x=%0d expected n=7 x=7", n, x);
            end
            if (last_c >= 0) begin
              n_cmp++;
              if (c - last_c !== 64) begin
                n_bad++;
                $display("FAIL wrap_fs_period: got %0d expected 64", c - last_c);
              end
            end
            last_c = c;
          end
          c++;
        end
      end
    end
    n_cmp++;
    if (fs_cnt !== 3) begin
      n_bad++;
      $display("FAIL wrap_fs_count: got %0d expected 3", fs_cnt);
    end
  endtask

  // Reset asserted between edges at line 2; outputs clear without a clock
  task automatic test_async_reset();
    logic [15:0] exp;
    s_hs  = 1'b0;
    s_hde = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int x = 0; x < 8; x++) begin
        if (n == 2 && x > 3) break;
        s_x = 10'(x);
        tick();
      end
    end
    exp = {1'b0, 1'b1, 1'b1, 1'b1, 10'd2, 1'b0, 1'b1};
    n_cmp++;
    if (s_obs !== exp) begin
      n_bad++;
      $display("FAIL async_pre: got %h expected %h", s_obs, exp);
    end
    #2;
    s_rst = 1'b1;
    #1;
    n_cmp++;
    if (s_obs !== RST_VEC) begin
      n_bad++;
      $display("FAIL async_immediate: got %h expected %h", s_obs, RST_VEC);
    end
    s_x = 10'd7;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (s_obs !== RST_VEC) begin
        n_bad++;
        $display("FAIL async_hold k=%0d: got %h expected %h", k, s_obs, RST_VEC);
      end
    end
    s_rst = 1'b0;
    for (int x = 4; x < 8; x++) begin
      s_x = 10'(x);
      tick();
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 10'd0, (x == 7), 1'b0};
      n_cmp++;
      if (s_obs !== exp) begin
        n_bad++;
        $display("FAIL async_relock x=%0d: got %h expected %h", x, s_obs, exp);
      end
    end
    for (int x = 0; x < 8; x++) begin
      s_x   = 10'(x);
      s_hde = (x < 5);
      tick();
      exp = {1'b0, 1'b1, 1'b1, s_hde, 10'd0, 1'b0, 1'b1};
      n_cmp++;
      if (s_obs !== exp) begin
        n_bad++;
        $display("FAIL async_line0 x=%0d: got %h expected %h", x, s_obs, exp);
      end
    end
  endtask

  // Column values at or beyond HTOTAL never count as a line end
  task automatic test_x_out_of_range();
    logic [9:0] xs_idle [8] = '{10'd8, 10'd9, 10'd15, 10'd100, 10'd1023, 10'd8, 10'd0, 10'd3};
    logic [9:0] xs_run  [4] = '{10'd8, 10'd1023, 10'd12, 10'd520};
    logic [15:0] exp;
    s_hs  = 1'b1;
    s_hde = 1'b0;
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_x = xs_idle[i];
      tick();
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0};
      n_cmp++;
      if (s_obs !== exp) begin
        n_bad++;
        $display("FAIL oor_idle x=%0d: got %h expected %h", xs_idle[i], s_obs, exp);
      end
    end
    s_x = 10'd7;
    tick();
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0};
    n_cmp++;
    if (s_obs !== exp) begin
      n_bad++;
      $display("FAIL oor_lock: got %h expected %h", s_obs, exp);
    end
    for (int i = 0; i < 4; i++) begin
      s_x = xs_run[i];
      tick();
      exp = {1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b1};
      n_cmp++;
      if (s_obs !== exp) begin
        n_bad++;
        $display("FAIL oor_run x=%0d: got %h expected %h", xs_run[i], s_obs, exp);
      end
    end
    s_x = 10'd7;
    tick();
    s_x = 10'd0;
    tick();
    n_cmp++;
    if (s_y !== 10'd1) begin
      n_bad++;
      $display("FAIL oor_advance: got y=%0d expected y=1", s_y);
    end
  endtask

  initial begin
    test_reset();
    test_lock_default();
    test_default_frame();
    test_line_count();
    test_wrap();
    test_async_reset();
    test_x_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
